serial_restador: RTL and testbench

- Bit-serial N-bit subtractor (A − B), the inverse-direction companion to the team's combinational 1-bit full adder.
- Operands load in parallel on a start strobe. One difference bit is produced per clock, LSB first, through a registered full-subtractor cell with a borrow flip-flop.
- Parallel difference and final borrow are presented with a one-cycle done pulse.
- Sits behind the Tiny Tapeout user wrapper: ui_in carries the operands, uo_out/uio carry the results.

---
 rtl/serial_restador.sv | 152 +++++++++++++++
 tb/tb_serial_restador.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_restador.sv
// ---------------------------------------------------------------------------
// serial_restador
//
// Bit-serial unsigned subtractor computing a - b, one difference bit per
// clock, LSB first. The operands are captured in parallel on an accepted
// start. A full-subtractor cell with a borrow flip-flop then walks across
// the captured operands. When the last bit has been processed, the parallel
// difference and the final borrow are loaded, and done pulses for one cycle.
//
// Parameters:
//   WIDTH      operand/result width in bits (2..16)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE or DONE
//   a          minuend, captured on accepted start
//   b          subtrahend, captured on accepted start
//   busy       high while the operation is shifting
//   done       one-cycle pulse when diff/borrow become valid
//   diff       parallel difference, held until the next completion
//   borrow     final borrow (1 when a < b unsigned), held with diff
//   bit_out    registered serial difference bit
//   bit_valid  high in each cycle bit_out carries a difference bit
//
// Optional build macro:
//   SERIAL_RESTADOR_SAT_EN  when defined, a result with final borrow = 1
//                           loads diff as 0 (saturating subtract). borrow
//                           and the serial bit stream are unchanged.
// ---------------------------------------------------------------------------
module serial_restador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             bit_out,
    output logic             bit_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;
    logic             bf;

    logic             d_bit;
    logic             bf_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] diff_load;
    logic             accept;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs, plus the result register
    // after this bit is shifted in from the top. After WIDTH shifts, the
    // first bit produced has reached bit 0.
    always_comb begin
        d_bit    = sa[0] ^ sb[0] ^ bf;
        bf_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf);
        r_next   = {d_bit, r[WIDTH-1:1]};
        accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
        last_bit = (state == ST_SHIFT) && (cnt == LAST_CNT);
`ifdef SERIAL_RESTADOR_SAT_EN
        diff_load = bf_next ? '0 : r_next;
`else
        diff_load = r_next;
`endif
    end

    // Sequencer and datapath. DONE behaves like IDLE for start acceptance,
    // so a held start gives a period of WIDTH+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            r     <= '0;
            cnt   <= '0;
            bf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        sa    <= a;
                        sb    <= b;
                        r     <= '0;
                        cnt   <= '0;
                        bf    <= 1'b0;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    r   <= r_next;
                    bf  <= bf_next;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Parallel result: loaded only on the edge that finishes the last bit.
    // It stays stable through any following operation until that one completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff   <= '0;
            borrow <= 1'b0;
        end else if (last_bit) begin
            diff   <= diff_load;
            borrow <= bf_next;
        end
    end

    // Serial stream: a registered copy of the cell output, so each bit
    // appears the cycle after the edge that computed it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= (state == ST_SHIFT);
            bit_out   <= (state == ST_SHIFT) ? d_bit : 1'b0;
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_restador.sv
// ---------------------------------------------------------------------------
// tb_serial_restador
//
// Self-checking bench for serial_restador at WIDTH = 4. A table holds the
// directed operand pairs and their expected results. Randomized operations
// are compared against a plain arithmetic model. Hand-written sequences
// cover a held start, start pulses during shifting, and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_serial_restador;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             bit_out;
    logic             bit_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_diff;
        logic             exp_borrow;
    } vec_t;

    vec_t vecs[7];

    serial_restador #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow    (borrow),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain modular arithmetic on the operands
    function automatic logic [WIDTH-1:0] modelRaw(input int x, input int y);
        return WIDTH'((x - y) & MASK);
    endfunction

    function automatic logic [WIDTH-1:0] modelDiff(input int x, input int y);
`ifdef SERIAL_RESTADOR_SAT_EN
        if (x < y) return '0;
`endif
        return modelRaw(x, y);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One full operation starting from IDLE or DONE. Outputs are checked at
    // every negedge from the capture edge to the done cycle. With disturb set,
    // a/b change while shifting and start pulses in SHIFT cycles 2 and 3.
    task automatic applyStimulus(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                                 input logic [WIDTH-1:0] exp_diff, input logic exp_borrow,
                                 input bit disturb, input string tag);
        logic [WIDTH-1:0] raw;
        raw = modelRaw(int'(op_a), int'(op_b));
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= WIDTH; k++) begin
            @(negedge clk);
            checkOutput({tag, " busy"}, int'(busy), (k < WIDTH) ? 1 : 0);
            checkOutput({tag, " bit_valid"}, int'(bit_valid), (k >= 1) ? 1 : 0);
            if (k >= 1) checkOutput({tag, " bit_out"}, int'(bit_out), int'(raw[k-1]));
            checkOutput({tag, " done"}, int'(done), (k == WIDTH) ? 1 : 0);
            if (k == WIDTH) begin
                checkOutput({tag, " diff"}, int'(diff), int'(exp_diff));
                checkOutput({tag, " borrow"}, int'(borrow), int'(exp_borrow));
            end
            if (disturb && k >= 1 && k < WIDTH) begin
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                start = (k == 2 || k == 3);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    // Timeout guard so the run always ends
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        vecs[0] = '{4'd9,  4'd5,  4'd4,  1'b0};
        vecs[2] = '{4'd0,  4'd0,  4'd0,  1'b0};
        vecs[4] = '{4'd15, 4'd15, 4'd0,  1'b0};
        vecs[5] = '{4'd7,  4'd2,  4'd5,  1'b0};
        vecs[6] = '{4'd3,  4'd1,  4'd2,  1'b0};
`ifdef SERIAL_RESTADOR_SAT_EN
        vecs[1] = '{4'd5,  4'd9,  4'd0,  1'b1};
        vecs[3] = '{4'd0,  4'd15, 4'd0,  1'b1};
`else
        vecs[1] = '{4'd5,  4'd9,  4'd12, 1'b1};
        vecs[3] = '{4'd0,  4'd15, 4'd1,  1'b1};
`endif

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset diff", int'(diff), 0);
        checkOutput("reset borrow", int'(borrow), 0);
        checkOutput("reset bit_out", int'(bit_out), 0);
        checkOutput("reset bit_valid", int'(bit_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle busy", int'(busy), 0);

        $display("[TB] directed table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow,
                          1'b0, $sformatf("vec%0d", i));
        end

        $display("[TB] randomized operations");
        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom_range(0, MASK));
            rb = WIDTH'($urandom_range(0, MASK));
            applyStimulus(ra, rb, modelDiff(int'(ra), int'(rb)), (ra < rb), 1'b0,
                          $sformatf("rand%0d", i));
        end

        $display("[TB] operand changes and start pulses while shifting");
        applyStimulus(4'd9, 4'd5, 4'd4, 1'b0, 1'b1, "disturb_a");
        applyStimulus(4'd2, 4'd11, modelDiff(2, 11), 1'b1, 1'b1, "disturb_b");

        $display("[TB] start held high");
        @(negedge clk);
        a     = 4'd7;
        b     = 4'd2;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput($sformatf("held done c%0d", c), int'(done), (c % 5 == 4) ? 1 : 0);
            if (c % 5 == 4) checkOutput($sformatf("held diff c%0d", c), int'(diff), 5);
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput("held release busy", int'(busy), 0);
        checkOutput("held release done", int'(done), 0);

        $display("[TB] reset mid-operation");
        applyStimulus(4'd7, 4'd2, 4'd5, 1'b0, 1'b0, "pre_reset");
        @(negedge clk);
        a     = 4'd9;
        b     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-abort busy", int'(busy), 1);
        checkOutput("pre-abort bit_valid", int'(bit_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort diff", int'(diff), 0);
        checkOutput("abort borrow", int'(borrow), 0);
        checkOutput("abort bit_valid", int'(bit_valid), 0);
        checkOutput("abort bit_out", int'(bit_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post-abort done c%0d", c), int'(done), 0);
            checkOutput($sformatf("post-abort busy c%0d", c), int'(busy), 0);
        end
        applyStimulus(4'd3, 4'd1, 4'd2, 1'b0, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
